// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder used as the single datapath cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock through one full adder.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             last;
  logic             load;
  logic             step;
  logic             busy_next;
  logic             done_next;
  logic             fa_s;
  logic             fa_c;

  assign last = (cnt == CW'(WIDTH - 1));

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? RUN : IDLE;
      RUN:        if (last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Control decode and next values of the registered status outputs
  always_comb begin
    load      = 1'b0;
    step      = 1'b0;
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
    case (state)
      IDLE, DONE: load = start;
      RUN:        step = 1'b1;
      default:    ;
    endcase
  end

  // Datapath: operand shifters, carry, result shift-in from the MSB end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (load) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= fa_c;
        sum   <= {fa_s, sum[WIDTH-1:1]};
        cnt   <= last ? '0 : cnt + CW'(1);
        if (last) begin
          cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into MSB is the carry register during the final bit
          ovf  <= carry ^ fa_c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed cases and WIDTH=4 exhaustive sweep.
// Define SERIAL_ADDER_OVF_EN to also check the overflow output.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, sub8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, sub4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int         checks = 0;
  int         passes = 0;
  logic [9:0] q8[$];
  logic [5:0] q4[$];
  logic [9:0] last8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Arithmetic reference: returns {ovf, cout, sum}
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    longint ua, ub, u, sa, sb, s, half, full;
    logic   co, ov;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    ua = longint'(a);
    ub = longint'(b);
    u  = sub ? ua - ub : ua + ub + longint'(cin);
    co = sub ? (ua >= ub) : u[w];
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    s  = sub ? sa - sb : sa + sb + longint'(cin);
    ov = (s >= half) || (s < -half);
    return {ov, co, 64'(u & (full - 1))};
  endfunction

  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    logic [65:0] m;
    m = model(8, 64'(a), 64'(b), c, s);
    q8.push_back({m[65], m[64], m[7:0]});
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy8_after_e0", 64'(busy8), 64'(1));
  endtask

  // Bounded wait for done; toggle drives garbage and start=1 every RUN cycle
  task automatic wait8(input bit toggle);
    int n = 0;
    int bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (toggle) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom); start8 = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (done8) break;
      if (busy8) bc++;
    end
    start8 = 1'b0;
    check("done8_latency", 64'(n), 64'(8));
    check("busy8_cycles", 64'(bc), 64'(7));
    last8 = q8.pop_front();
    check("sum8", 64'(sum8), 64'(last8[7:0]));
    check("cout8", 64'(cout8), 64'(last8[8]));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf8", 64'(ovf8), 64'(last8[9]));
`endif
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    check("done8_one_cycle", 64'(done8), 64'(0));
    check("busy8_idle", 64'(busy8), 64'(0));
    check("sum8_hold", 64'(sum8), 64'(last8[7:0]));
    check("cout8_hold", 64'(cout8), 64'(last8[8]));
  endtask

  task automatic start4_op(input logic [3:0] a, input logic [3:0] b, input logic c, input logic s);
    logic [65:0] m;
    m = model(4, 64'(a), 64'(b), c, s);
    q4.push_back({m[65], m[64], m[3:0]});
    a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait4();
    logic [5:0] e;
    bit         seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        seen = 1'b1;
        break;
      end
    end
    e = q4.pop_front();
    if (!seen) check("done4_timeout", 64'(0), 64'(1));
    check("sum4", 64'(sum4), 64'(e[3:0]));
    check("cout4", 64'(cout4), 64'(e[4]));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf4", 64'(ovf4), 64'(e[5]));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_done8", 64'(done8), 64'(0));
    check("rst_sum8", 64'(sum8), 64'(0));
    check("rst_cout8", 64'(cout8), 64'(0));
    check("rst_busy4", 64'(busy4), 64'(0));
    check("rst_sum4", 64'(sum4), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf8", 64'(ovf8), 64'(0));
`endif
    rst = 1'b0;

    // Basic add: 3C + 0F
    start8_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait8(1'b0);
    idle8();

    // FF + 01 + 1, then back-to-back subtract 05 - 07 started in DONE
    start8_op(8'hFF, 8'h01, 1'b1, 1'b0);
    wait8(1'b0);
    start8_op(8'h05, 8'h07, 1'b0, 1'b1);
    wait8(1'b0);
    idle8();

    // Signed overflow corners
    start8_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8(1'b0);
    start8_op(8'h80, 8'h01, 1'b0, 1'b1);
    wait8(1'b0);
    idle8();

    // Reset at E4 with start also asserted; new start on the very next edge
    start8_op(8'hA5, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(posedge clk); #1;
    check("midrst_busy8", 64'(busy8), 64'(0));
    check("midrst_done8", 64'(done8), 64'(0));
    check("midrst_sum8", 64'(sum8), 64'(0));
    check("midrst_cout8", 64'(cout8), 64'(0));
    void'(q8.pop_back());
    rst = 1'b0;
    start8_op(8'hC3, 8'h5A, 1'b1, 1'b0);
    wait8(1'b0);
    idle8();

    // Operands and start toggled during RUN must not disturb the result
    start8_op(8'h5A, 8'h21, 1'b1, 1'b0);
    wait8(1'b1);
    idle8();

    // A few random operations, alternately back-to-back
    for (int i = 0; i < 6; i++) begin
      start8_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait8(1'b0);
      if (i[0]) idle8();
    end

    // WIDTH=4 exhaustive sweep, issued back-to-back
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) begin
            start4_op(4'(x), 4'(y), 1'(c), 1'(s));
            wait4();
          end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
